instr_mem_ctrl: RTL and testbench
=================================

# instr_mem_ctrl

Parametrised instruction memory with a runtime programming port and a handshaked fetch port. It replaces the fixed 8x16 ROM-style instruction store. It sits between the fetch stage (PC source) and decode. After reset it clears itself to NOP and accepts program loads at runtime. It returns one instruction per cycle with a registered output that holds under decode back-pressure.

## Interface
- DATA_W, 16, instruction width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
- NOP, {DATA_W{1'b0}}, value written by the clear sequence and driven on instr at reset

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- prog_en  in  1  write strobe for program load
- prog_addr  in  ADDR_W  program load address
- prog_data  in  DATA_W  program load data
- prog_ready  out  1  high when writes are accepted (state RUN)
- fetch_req  in  1  fetch request from PC stage
- fetch_addr  in  ADDR_W  fetch address (PC)
- fetch_ready  out  1  fetch accepted this cycle when fetch_req && fetch_ready
- instr_valid  out  1  instr holds a fetched word
- instr  out  DATA_W  fetched instruction
- instr_ready  in  1  decode consumes instr when instr_valid && instr_ready

## Operation
- FSM has 2 states: CLEAR and RUN.
- **CLEAR**
  - Entered on rst.
  - Writes NOP to mem[clr_addr], one word per cycle, with clr_addr counting 0..DEPTH-1.
  - Moves to RUN on the cycle after writing DEPTH-1.
  - prog_ready=0 and fetch_ready=0 throughout.
- **RUN**
  - Stays in RUN until rst.
  - prog_ready=1.
  - prog_en writes prog_data to mem[prog_addr] at the clock edge.
- **Dropped writes:** prog_en while prog_ready=0 is ignored; no buffering.
- **fetch_ready** = (state==RUN) && !prog_en && (!instr_valid || instr_ready).
  - Programming has priority over fetch, so read and write never collide in one cycle.
- **Accepted fetch:** instr <= mem[fetch_addr] and instr_valid <= 1.
- **No accepted fetch:**
  - If instr_valid && instr_ready, then instr_valid <= 0, and instr keeps its last value.
  - If instr_valid && !instr_ready, then instr and instr_valid hold (stall).
- **Address wrap:** addresses are modulo DEPTH by width; there is no out-of-range case.
- **Width:** memory is DEPTH x DATA_W. There is no byte enable; writes are whole-word.

## Timing
- **Reset values (asynchronous):**
  - state=CLEAR, clr_addr=0
  - instr_valid=0, instr=NOP
  - prog_ready=0, fetch_ready=0
  - Memory contents are unchanged by rst itself and are overwritten by CLEAR.
- **CLEAR duration:** exactly DEPTH cycles after rst deasserts. prog_ready and fetch_ready rise on cycle DEPTH+1.
- **Reset during CLEAR:** restarts at clr_addr=0 with the full DEPTH-cycle sequence.
- **Reset in RUN:** drops any pending instr_valid, then re-clears memory. A program written before reset is lost.
- **Fetch latency:** 1 cycle. A request accepted at edge k gives instr_valid=1 and instr=mem[addr] after edge k.
- **Throughput:** back-to-back, one per cycle while instr_ready=1. The same-cycle transfer and new accept is allowed.
- **Write-then-read:** a write at edge k is visible to a fetch accepted at edge k+1 or later.
- **Stall:** instr must be bit-stable while instr_valid && !instr_ready.

## Structure
- Shared package (cpu_pkg) holds:
  - DATA_W/ADDR_W defaults
  - the NOP encoding
  - the opcode/func field widths (3/3/3/3/4) used by decode
  - the state encoding localparams CLEAR=1'b0, RUN=1'b1
- Sub-module mem_array (DEPTH x DATA_W, 1 write port, 1 synchronous read port) is natural. The controller, clear counter and output register live in instr_mem_ctrl.

## Test plan
- **Reset/clear:** assert rst mid-run, release, DEPTH=8.
  - fetch_ready=0 for exactly 8 cycles, then 1.
  - Fetching addresses 0..7 returns 16'h0000.
- **Program and fetch:** write 16'h1200 to addr 0 and 16'h2281 to addr 1, then fetch 0,1 back-to-back with instr_ready=1.
  - instr=16'h1200, then 16'h2281 on consecutive cycles, instr_valid high for 2 cycles.
- **Back-pressure:** fetch addr 1, hold instr_ready=0 for 3 cycles with fetch_req=1.
  - instr stays 16'h2281.
  - fetch_ready=0 for all 3 cycles; no word is lost or duplicated.
- **Write priority:** prog_en=1 (addr 2, 16'h3344) and fetch_req=1 (addr 2) in the same cycle.
  - fetch_ready=0 that cycle.
  - The next-cycle fetch of addr 2 returns 16'h3344.
- **Reset mid-CLEAR and dropped writes:** assert rst at clear cycle 4, and pulse prog_en during CLEAR.
  - Clear restarts from 0 and lasts a full 8 cycles.
  - The write during CLEAR is ignored; that address reads 16'h0000.
- **Parameter sweep:** DATA_W=32, ADDR_W=5.
  - CLEAR lasts 32 cycles.
  - Writes at addrs 0 and 31 read back correctly, and address 31+1 wraps to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, NOP encoding, instruction field widths, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // All-zero word decodes as NOP.
  localparam logic [DATA_W_DEF-1:0] NOP_ENC = '0;

  // Instruction field widths consumed by decode: opcode / rd / rs / rt / func.
  localparam int OPCODE_W = 3;
  localparam int RD_W     = 3;
  localparam int RS_W     = 3;
  localparam int RT_W     = 3;
  localparam int FUNC_W   = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with one write port and one enabled synchronous read port.
// Latency: 1 cycle from re to rdata; rdata holds its value while re is low.
// Backpressure: none internally; the caller holds rdata by keeping re low.
// Ports: clk/rst, we/waddr/wdata (write), re/raddr (read request), rdata (registered read data).
module mem_array #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 3,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage itself is not reset; the controller's clear sequence initialises it.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the fetched-instruction output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= RST_VAL;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with self-clear after reset, runtime program port and handshaked fetch port.
// Latency: 1 cycle from accepted fetch to instr_valid; clear takes DEPTH cycles after reset.
// Backpressure: instr/instr_valid hold while !instr_ready; fetch_ready drops; prog_en blocks fetch.
// Ports: clk, rst (async, active-high);
//        prog_en/prog_addr/prog_data in, prog_ready out (writes accepted only in RUN);
//        fetch_req/fetch_addr in, fetch_ready out;
//        instr_valid/instr out, instr_ready in.
module instr_mem_ctrl
  import cpu_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DEF,
  parameter int                ADDR_W = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_ENC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              instr_ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              fetch_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Clear FSM: one NOP write per cycle, leaves CLEAR after the last address is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state <= RUN;
          end
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  assign prog_ready = (state == RUN);

  // A program write in the same cycle wins over fetch, so the array never sees a
  // read and a write together. The output slot may be refilled while it drains.
  assign fetch_ready = prog_ready && !prog_en && (!instr_valid || instr_ready);
  assign fetch_acc   = fetch_req && fetch_ready;

  // Write port is owned by the clear sequence in CLEAR; prog_en outside RUN is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = prog_addr;
    mem_wdata = prog_data;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = NOP;
    end else if (prog_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
    end else if (fetch_acc) begin
      instr_valid <= 1'b1;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  mem_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RST_VAL (NOP)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (fetch_acc),
    .raddr (fetch_addr),
    .rdata (instr)
  );

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: default 16x8 instance and a 32-bit x 32-word instance.
// Expected words are pushed on accepted fetches; a negedge monitor pops them on consumption.
// Stall stability, readiness and reset values are checked every cycle.
module tb_instr_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DATA_W=16, ADDR_W=3
  logic        rst0, pe0, fr0, ir0;
  logic [2:0]  pa0, fa0;
  logic [15:0] pd0;
  logic        prdy0, frdy0, iv0;
  logic [15:0] ins0;

  // Instance 1: DATA_W=32, ADDR_W=5
  logic        rst1, pe1, fr1, ir1;
  logic [4:0]  pa1, fa1;
  logic [31:0] pd1;
  logic        prdy1, frdy1, iv1;
  logic [31:0] ins1;

  instr_mem_ctrl u0 (
    .clk(clk), .rst(rst0),
    .prog_en(pe0), .prog_addr(pa0), .prog_data(pd0), .prog_ready(prdy0),
    .fetch_req(fr0), .fetch_addr(fa0), .fetch_ready(frdy0),
    .instr_valid(iv0), .instr(ins0), .instr_ready(ir0)
  );

  instr_mem_ctrl #(.DATA_W(32), .ADDR_W(5)) u1 (
    .clk(clk), .rst(rst1),
    .prog_en(pe1), .prog_addr(pa1), .prog_data(pd1), .prog_ready(prdy1),
    .fetch_req(fr1), .fetch_addr(fa1), .fetch_ready(frdy1),
    .instr_valid(iv1), .instr(ins1), .instr_ready(ir1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: word store, expected-output FIFO, cycles since reset release.
  logic [31:0] mem_m   [2][32];
  logic [31:0] exp_buf [2][16];
  int          head [2];
  int          tail [2];
  int          cnt0, cnt1;

  always @(posedge clk or posedge rst0) begin
    if (rst0) cnt0 <= 0;
    else if (cnt0 < 8) cnt0 <= cnt0 + 1;
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) cnt1 <= 0;
    else if (cnt1 < 32) cnt1 <= cnt1 + 1;
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input int cnt, input logic rst_s,
                     input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                     input logic fr, input logic [4:0] fa, input logic ir,
                     input logic p_rdy, input logic f_rdy, input logic iv, input logic [31:0] ins);
    int   depth;
    logic run, have, exp_fr;
    depth = (d == 0) ? 8 : 32;
    if (rst_s) begin
      chk("rst_instr_valid", d, 32'(iv), 32'd0);
      chk("rst_instr", d, ins, 32'd0);
      chk("rst_prog_ready", d, 32'(p_rdy), 32'd0);
      chk("rst_fetch_ready", d, 32'(f_rdy), 32'd0);
      tail[d] = head[d];
      for (int i = 0; i < 32; i++) mem_m[d][i] = 32'd0;
      return;
    end
    run    = (cnt == depth);
    have   = (head[d] != tail[d]);
    exp_fr = run && !pe && (!have || ir);
    chk("prog_ready", d, 32'(p_rdy), 32'(run));
    chk("fetch_ready", d, 32'(f_rdy), 32'(exp_fr));
    if (have) begin
      chk("instr_valid", d, 32'(iv), 32'd1);
      chk("instr", d, ins, exp_buf[d][head[d] % 16]);
      if (ir) head[d]++;
    end else begin
      chk("instr_valid", d, 32'(iv), 32'd0);
    end
    if (fr && exp_fr) begin
      exp_buf[d][tail[d] % 16] = mem_m[d][int'(fa) % depth];
      tail[d]++;
    end
    if (run && pe) mem_m[d][int'(pa) % depth] = pd;
  endtask

  always @(negedge clk) begin
    mon(0, cnt0, rst0, pe0, {2'b0, pa0}, {16'h0, pd0}, fr0, {2'b0, fa0}, ir0,
        prdy0, frdy0, iv0, {16'h0, ins0});
    mon(1, cnt1, rst1, pe1, pa1, pd1, fr1, fa1, ir1, prdy1, frdy1, iv1, ins1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a;
    head[0] = 0; head[1] = 0; tail[0] = 0; tail[1] = 0;
    for (int i = 0; i < 32; i++) begin
      mem_m[0][i] = 32'd0;
      mem_m[1][i] = 32'd0;
    end
    rst0 = 1'b1; pe0 = 1'b0; pa0 = '0; pd0 = '0; fr0 = 1'b0; fa0 = '0; ir0 = 1'b1;
    rst1 = 1'b1; pe1 = 1'b0; pa1 = '0; pd1 = '0; fr1 = 1'b0; fa1 = '0; ir1 = 1'b1;
    repeat (3) step();

    // Clear: 8 cycles of fetch_ready=0, then every address reads NOP.
    rst0 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      fr0 = 1'b1; fa0 = 3'(i);
      step();
    end
    fr0 = 1'b0;
    step();

    // Program two words, fetch them back-to-back.
    pe0 = 1'b1; pa0 = 3'd0; pd0 = 16'h1200; step();
    pa0 = 3'd1; pd0 = 16'h2281; step();
    pe0 = 1'b0; fr0 = 1'b1; fa0 = 3'd0; step();
    fa0 = 3'd1; step();
    fr0 = 1'b0; repeat (2) step();

    // Back-pressure: fetch addr 1 then stall 3 cycles with fetch_req held.
    fr0 = 1'b1; fa0 = 3'd1; ir0 = 1'b0; step();
    fa0 = 3'd3; repeat (3) step();
    fr0 = 1'b0; ir0 = 1'b1; repeat (2) step();

    // Write priority over a same-cycle fetch of the same address.
    pe0 = 1'b1; pa0 = 3'd2; pd0 = 16'h3344; fr0 = 1'b1; fa0 = 3'd2; step();
    pe0 = 1'b0; step();
    fr0 = 1'b0; step();

    // Reset in RUN with a word pending, then reset again at clear cycle 4.
    fr0 = 1'b1; fa0 = 3'd1; ir0 = 1'b0; step();
    fr0 = 1'b0; step();
    rst0 = 1'b1; repeat (2) step();
    rst0 = 1'b0; ir0 = 1'b1; repeat (2) step();
    pe0 = 1'b1; pa0 = 3'd5; pd0 = 16'hbeef; step();
    pe0 = 1'b0; step();
    rst0 = 1'b1; step();
    rst0 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      fr0 = 1'b1; fa0 = 3'(i);
      pe0 = (i == 3); pa0 = 3'd5; pd0 = 16'hbeef;
      step();
    end
    pe0 = 1'b0; fr0 = 1'b0; step();

    // Randomised traffic on the default instance.
    for (int i = 0; i < 400; i++) begin
      pe0 = ($urandom_range(0, 3) == 0);
      pa0 = 3'($urandom_range(0, 7));
      pd0 = 16'($urandom);
      fr0 = ($urandom_range(0, 3) != 0);
      fa0 = 3'($urandom_range(0, 7));
      ir0 = ($urandom_range(0, 3) != 0);
      step();
    end
    pe0 = 1'b0; fr0 = 1'b0; ir0 = 1'b1; repeat (2) step();

    // Wide instance: 32-cycle clear, edge addresses, wrap of 31+1.
    rst1 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      fr1 = 1'b1; fa1 = 5'(i);
      step();
    end
    fr1 = 1'b0; step();
    pe1 = 1'b1; pa1 = 5'd0;  pd1 = 32'hcafe_0001; step();
    pa1 = 5'd31; pd1 = 32'hdead_beef; step();
    pe1 = 1'b0; fr1 = 1'b1; fa1 = 5'd0; step();
    fa1 = 5'd31; step();
    a = 31 + 1;
    fa1 = 5'(a); step();
    fr1 = 1'b0; step();
    for (int i = 0; i < 300; i++) begin
      pe1 = ($urandom_range(0, 3) == 0);
      pa1 = 5'($urandom_range(0, 31));
      pd1 = $urandom;
      fr1 = ($urandom_range(0, 3) != 0);
      fa1 = 5'($urandom_range(0, 31));
      ir1 = ($urandom_range(0, 3) != 0);
      step();
    end
    pe1 = 1'b0; fr1 = 1'b0; ir1 = 1'b1; repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
